// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared types and helpers for ripple-carry adder consumers
package rca_pkg;

  localparam int RCA_W     = 4;
  localparam int RCA_RES_W = RCA_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Gathers the adder's scalar outputs into one {Cout,S3..S0} value.
  function automatic logic [RCA_RES_W-1:0] rca_pack_result(
    input logic cout,
    input logic s3,
    input logic s2,
    input logic s1,
    input logic s0
  );
    logic [RCA_W-1:0] s;
    s = {s3, s2, s1, s0};
    return {cout, s};
  endfunction

endpackage

// File: rtl/rca_sum_accumulator.sv
// rtl/rca_sum_accumulator.sv - accumulates N_OPS adder results into a valid/ready total
module rca_sum_accumulator
  import rca_pkg::*;
#(
  parameter int ACC_W = 8,
  parameter int N_OPS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             S3,
  input  logic             S2,
  input  logic             S1,
  input  logic             S0,
  input  logic             Cout,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic [3:0]       op_count,
  output logic             ovf
);

  localparam logic [3:0] LAST_CNT = 4'(N_OPS);

  state_t               state;
  logic [RCA_RES_W-1:0] res;
  logic [ACC_W:0]       add_v;
  logic [ACC_W:0]       sum;
  logic [3:0]           cnt_nxt;
  logic                 accept;

  assign res      = rca_pack_result(Cout, S3, S2, S1, S0);
  assign add_v    = {{(ACC_W + 1 - RCA_RES_W){1'b0}}, res};
  assign sum      = {1'b0, acc} + add_v;
  assign cnt_nxt  = op_count + 4'd1;
  assign in_ready = (state != HOLD);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      op_count  <= 4'd0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (acc_clr && accept) begin
      // Clear restarts the total with the coincident result rather than dropping it.
      acc       <= add_v[ACC_W-1:0];
      op_count  <= 4'd1;
      ovf       <= 1'b0;
      state     <= (N_OPS == 1) ? HOLD : ACCUM;
      out_valid <= (N_OPS == 1);
    end else if (acc_clr) begin
      state     <= IDLE;
      acc       <= '0;
      op_count  <= 4'd0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc       <= add_v[ACC_W-1:0];
            op_count  <= 4'd1;
            state     <= (N_OPS == 1) ? HOLD : ACCUM;
            out_valid <= (N_OPS == 1);
          end
        end
        ACCUM: begin
          if (accept) begin
            acc      <= sum[ACC_W-1:0];
            ovf      <= ovf | sum[ACC_W];
            op_count <= cnt_nxt;
            if (cnt_nxt == LAST_CNT) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            acc       <= '0;
            op_count  <= 4'd0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          acc       <= '0;
          op_count  <= 4'd0;
          ovf       <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_sum_accumulator.sv
// tb/tb_rca_sum_accumulator.sv - scoreboard bench for two accumulator configurations
module tb_rca_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] r0 = '0, r1 = '0;
  logic       iv0 = 1'b0, iv1 = 1'b0, clr0 = 1'b0, clr1 = 1'b0, ordy0 = 1'b0, ordy1 = 1'b0;
  logic       ir0, ir1, ov0, ov1, ovf0, ovf1;
  logic [7:0] acc0;
  logic [5:0] acc1;
  logic [3:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rca_sum_accumulator #(.ACC_W(8), .N_OPS(4)) u0 (
    .clk(clk), .rst_n(rst_n),
    .S3(r0[3]), .S2(r0[2]), .S1(r0[1]), .S0(r0[0]), .Cout(r0[4]),
    .in_valid(iv0), .in_ready(ir0), .acc_clr(clr0),
    .out_valid(ov0), .out_ready(ordy0),
    .acc(acc0), .op_count(cnt0), .ovf(ovf0)
  );

  rca_sum_accumulator #(.ACC_W(6), .N_OPS(3)) u1 (
    .clk(clk), .rst_n(rst_n),
    .S3(r1[3]), .S2(r1[2]), .S1(r1[1]), .S0(r1[0]), .Cout(r1[4]),
    .in_valid(iv1), .in_ready(ir1), .acc_clr(clr1),
    .out_valid(ov1), .out_ready(ordy1),
    .acc(acc1), .op_count(cnt1), .ovf(ovf1)
  );

  typedef struct {
    int acc;
    int cnt;
    bit ovf;
    bit hold;
  } mst_t;

  typedef struct {
    int inst;
    int acc;
    int cnt;
    bit ovf;
    bit hold;
  } exp_t;

  mst_t m[2];
  exp_t q[$];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic mst_t model(input mst_t s, input int w, input int n, input bit rst,
                                 input bit iv, input int v, input bit clr, input bit ordy);
    mst_t t;
    int   total;
    t = s;
    if (rst) begin
      t = '{0, 0, 1'b0, 1'b0};
    end else if (clr) begin
      if (!s.hold && iv) t = '{v, 1, 1'b0, n == 1};
      else t = '{0, 0, 1'b0, 1'b0};
    end else if (s.hold) begin
      if (ordy) t = '{0, 0, 1'b0, 1'b0};
    end else if (iv) begin
      total = s.acc + v;
      t.ovf  = s.ovf | (total >= (1 << w));
      t.acc  = total % (1 << w);
      t.cnt  = s.cnt + 1;
      t.hold = (t.cnt == n);
    end
    return t;
  endfunction

  task automatic step(input int sel, input bit rst, input bit iv, input int v,
                      input bit clr, input bit ordy);
    exp_t e0, e1;
    rst_n = ~rst;
    if (sel == 0) begin
      r0 = 5'(v); iv0 = iv; clr0 = clr; ordy0 = ordy;
      r1 = '0;    iv1 = 0;  clr1 = 0;   ordy1 = 0;
      m[0] = model(m[0], 8, 4, rst, iv, v, clr, ordy);
      m[1] = model(m[1], 6, 3, rst, 0, 0, 0, 0);
    end else begin
      r1 = 5'(v); iv1 = iv; clr1 = clr; ordy1 = ordy;
      r0 = '0;    iv0 = 0;  clr0 = 0;   ordy0 = 0;
      m[1] = model(m[1], 6, 3, rst, iv, v, clr, ordy);
      m[0] = model(m[0], 8, 4, rst, 0, 0, 0, 0);
    end
    e0 = '{0, m[0].acc, m[0].cnt, m[0].ovf, m[0].hold};
    e1 = '{1, m[1].acc, m[1].cnt, m[1].ovf, m[1].hold};
    q.push_back(e0);
    q.push_back(e1);
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.inst == 0) begin
        check("u0.acc", int'(acc0), e.acc);
        check("u0.op_count", int'(cnt0), e.cnt);
        check("u0.ovf", int'(ovf0), int'(e.ovf));
        check("u0.out_valid", int'(ov0), int'(e.hold));
        check("u0.in_ready", int'(ir0), int'(!e.hold));
      end else begin
        check("u1.acc", int'(acc1), e.acc);
        check("u1.op_count", int'(cnt1), e.cnt);
        check("u1.ovf", int'(ovf1), int'(e.ovf));
        check("u1.out_valid", int'(ov1), int'(e.hold));
        check("u1.in_ready", int'(ir1), int'(!e.hold));
      end
    end
  endtask

  initial begin
    m[0] = '{0, 0, 1'b0, 1'b0};
    m[1] = '{0, 0, 1'b0, 1'b0};
    @(posedge clk);
    #1;
    repeat (2) step(0, 1, 0, 0, 0, 0);
    check("reset_acc", int'(acc0), 0);
    check("reset_in_ready", int'(ir0), 1);

    // Basic four-result total: 7, 16, 29, 60
    step(0, 0, 1, 7, 0, 0);
    check("seq_acc1", int'(acc0), 7);
    step(0, 0, 1, 9, 0, 0);
    check("seq_acc2", int'(acc0), 16);
    step(0, 0, 1, 13, 0, 0);
    check("seq_acc3", int'(acc0), 29);
    step(0, 0, 1, 31, 0, 0);
    check("seq_acc4", int'(acc0), 60);
    check("seq_out_valid", int'(ov0), 1);
    check("seq_in_ready", int'(ir0), 0);

    // Held in HOLD with in_valid high carrying 5; nothing may move
    repeat (5) step(0, 0, 1, 5, 0, 0);
    check("hold_acc", int'(acc0), 60);
    check("hold_cnt", int'(cnt0), 4);
    step(0, 0, 0, 0, 0, 1);
    check("handshake_acc", int'(acc0), 0);
    check("handshake_in_ready", int'(ir0), 1);
    step(0, 0, 1, 5, 0, 0);
    check("after_hold_acc", int'(acc0), 5);
    check("after_hold_cnt", int'(cnt0), 1);

    // Reset while accumulating with acc=16 (starts from acc=5 here: 5+11=16)
    step(0, 0, 1, 11, 0, 0);
    check("pre_reset_acc", int'(acc0), 16);
    step(0, 1, 1, 3, 0, 0);
    check("mid_reset_acc", int'(acc0), 0);
    check("mid_reset_cnt", int'(cnt0), 0);

    // acc_clr with simultaneous accept of 9 while acc=20, op_count=2
    step(0, 0, 1, 11, 0, 0);
    step(0, 0, 1, 9, 0, 0);
    check("pre_clr_acc", int'(acc0), 20);
    step(0, 0, 1, 9, 1, 0);
    check("clr_accept_acc", int'(acc0), 9);
    check("clr_accept_cnt", int'(cnt0), 1);
    step(0, 0, 0, 0, 1, 0);
    check("clr_idle_acc", int'(acc0), 0);
    repeat (4) step(0, 0, 1, 2, 0, 0);
    step(0, 0, 1, 4, 1, 1);
    check("clr_in_hold_valid", int'(ov0), 0);
    check("clr_in_hold_cnt", int'(cnt0), 0);

    // Narrow instance: 31+31+31 wraps modulo 64
    step(1, 0, 1, 31, 0, 0);
    check("w6_acc1", int'(acc1), 31);
    step(1, 0, 1, 31, 0, 0);
    check("w6_acc2", int'(acc1), 62);
    check("w6_ovf2", int'(ovf1), 0);
    step(1, 0, 1, 31, 0, 0);
    check("w6_acc3", int'(acc1), 29);
    check("w6_ovf3", int'(ovf1), 1);
    step(1, 0, 0, 0, 0, 0);
    check("w6_ovf_hold", int'(ovf1), 1);
    step(1, 0, 0, 0, 0, 1);
    check("w6_ovf_cleared", int'(ovf1), 0);

    // Random traffic on both configurations
    for (int i = 0; i < 400; i++) begin
      step(int'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
